fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences reads of the 396-word instruction memory on behalf of the decode stage. Each cycle it presents a word-aligned byte address to the memory's combinational read port, captures the returned word with its PC into a 2-entry prefetch buffer, and hands instructions to decode with a valid/ready handshake. It handles branch/jump redirects with a buffer flush, and stops fetching at the end of the memory image.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] are ignored.
- IMEM_WORDS, 396, instruction memory depth in words; the fetch limit is IMEM_WORDS*4.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- IMemAddress  out  32  byte address to the instruction memory; always equals PC, bits [1:0] = 0.
- IMemInstruction  in  32  word returned combinationally for IMemAddress.
- Redirect  in  1  branch/jump taken; one-cycle pulse.
- RedirectPC  in  32  target byte address; bits [1:0] forced to 0.
- InstrReady  in  1  decode accepts the head entry this cycle.
- InstrValid  out  1  head entry is valid.
- Instruction  out  32  head entry instruction word.
- InstrPC  out  32  byte address of the head entry.
- Halted  out  1  high while in state HALT.

## Operation
- State: PC (32), FIFO of 2 entries {instr, pc}, count (0..2), FSM {RUN, HALT}.
- Push condition: state RUN, no Redirect, and (count<2 or a pop occurs this cycle). A push writes {IMemInstruction, PC} and sets PC = PC+4.
- Pop condition: InstrValid && InstrReady && !Redirect.
- A push and a pop in the same cycle are legal at any count, including full. Count is unchanged and order is preserved.
- Redirect has priority over everything:
  - FIFO is flushed (count=0).
  - PC = {RedirectPC[31:2],2'b00}.
  - FSM goes to RUN.
  - No push occurs. A handshake in that cycle is not an acceptance, and decode must treat the head as discarded.
- End of memory: when a push makes PC+4 >= IMEM_WORDS*4, the FSM goes RUN→HALT after that push. In HALT no pushes occur, and buffered entries still drain normally.
- Redirect to an address >= IMEM_WORDS*4: PC is loaded and the FSM goes to HALT, not RUN. No out-of-range fetch ever occurs.
- PC arithmetic is 32-bit with wrap. The limit check prevents the wrap from being reached.

## Timing
- Reset values:
  - PC=RESET_PC&~3, IMemAddress=that value.
  - count=0, InstrValid=0, Instruction=0, InstrPC=0.
  - FSM=RUN, Halted=0. If RESET_PC>=IMEM_WORDS*4, FSM=HALT and Halted=1.
- Fetch latency: the word at address A is visible on Instruction/InstrValid one cycle after the edge at which IMemAddress=A was captured. The first instruction appears after the first rising edge following Reset deassertion.
- Throughput: 1 instruction/cycle while InstrReady stays high.
- Redirect penalty: the target instruction is valid 2 edges after the Redirect edge. Edge 1 loads PC; edge 2 pushes the target.
- Backpressure: with InstrReady low, 2 entries fill in 2 cycles, then PC holds.
- Outputs Instruction, InstrPC, InstrValid and Halted are registered, with no combinational path from InstrReady or Redirect. IMemAddress is PC, a register output.
- Reset asserted mid-operation: all state returns to reset values asynchronously. In-flight entries are lost.

## Configuration
- FETCH_PERF_EN defined:
  - Adds output port FetchCount (out, 32): the number of pushes since reset, wrapping at 2^32.
  - Adds output port FlushCount (out, 32): the number of Redirect cycles that discarded at least one buffered entry.
  - Both counters reset to 0.
- FETCH_PERF_EN undefined: neither port nor counter exists, and behaviour is otherwise identical.

## Test plan
- Memory preloaded with memory[i]=i*4, RESET_PC=0, InstrReady=1 -> Instruction/InstrPC show 0,4,8,… one per cycle starting 1 cycle after reset release.
- InstrReady=0 for 5 cycles, then 1 -> PC stops at 8 (2 entries held: PC 0,4), then the stream resumes 0,4,8 with no gap or duplicate.
- Redirect with RedirectPC=32'h43 while full -> buffer flushed, the head handshake is ignored, and the next valid entry is InstrPC=0x40, instr=0x40, 2 cycles later.
- Run from PC 0x620 -> pushes 0x620,0x624,0x628,0x62C, then Halted=1 with IMemAddress=0x630 never read. A Redirect to 0x10 leaves HALT.
- Reset pulsed asynchronously mid-cycle while streaming -> InstrValid=0 and PC=RESET_PC immediately, before the next edge.
- With FETCH_PERF_EN defined: 10 accepted fetches plus one flushing redirect -> FetchCount counts every push (10 + buffered extras), and FlushCount=1.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction memory read port, redirect request and
// decode handshake. The sequencer takes the master modport, its environment the slave.
interface fetch_sequencer_if;
    logic [31:0] IMemAddress;
    logic [31:0] IMemInstruction;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        InstrReady;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic        Halted;

    modport master (
        output IMemAddress,
        input  IMemInstruction,
        input  Redirect,
        input  RedirectPC,
        input  InstrReady,
        output InstrValid,
        output Instruction,
        output InstrPC,
        output Halted
    );

    modport slave (
        input  IMemAddress,
        output IMemInstruction,
        output Redirect,
        output RedirectPC,
        output InstrReady,
        input  InstrValid,
        input  Instruction,
        input  InstrPC,
        input  Halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC, 2-entry prefetch buffer, redirect flush, end-of-image halt.
// Optional FETCH_PERF_EN adds FetchCount/FlushCount performance counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 396
) (
    input  logic               Clk,
    input  logic               Reset,
    fetch_sequencer_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        FetchCount,
    output logic [31:0]        FlushCount
`endif
);

    localparam logic [32:0] LIMIT          = 33'(IMEM_WORDS * 4);
    localparam logic [31:0] RESET_PC_ALIGN = RESET_PC & ~32'd3;
    localparam logic [0:0]  ST_RUN         = 1'b0;
    localparam logic [0:0]  ST_HALT        = 1'b1;
    localparam logic [0:0]  ST_RESET       = ({1'b0, RESET_PC_ALIGN} >= LIMIT) ? ST_HALT : ST_RUN;

    logic [31:0] pc_q, pc_d;
    logic [0:0]  state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] instr0_q, instr0_d, pc0_q, pc0_d;
    logic [31:0] instr1_q, instr1_d, pc1_q, pc1_d;

    logic        pop;
    logic        push;
    logic [32:0] pc_next_wide;
    logic [31:0] redirect_pc;

    assign pop          = (count_q != 2'd0) && bus.InstrReady && !bus.Redirect;
    assign push         = (state_q == ST_RUN) && !bus.Redirect && ((count_q != 2'd2) || pop);
    // Widened so the limit compare cannot be fooled by 32-bit wrap.
    assign pc_next_wide = {1'b0, pc_q} + 33'd4;
    assign redirect_pc  = bus.RedirectPC & ~32'd3;

    always_comb begin
        pc_d     = pc_q;
        state_d  = state_q;
        count_d  = count_q;
        instr0_d = instr0_q;
        pc0_d    = pc0_q;
        instr1_d = instr1_q;
        pc1_d    = pc1_q;

        if (bus.Redirect) begin
            count_d = 2'd0;
            pc_d    = redirect_pc;
            state_d = ({1'b0, redirect_pc} >= LIMIT) ? ST_HALT : ST_RUN;
        end else begin
            if (push) begin
                pc_d = pc_next_wide[31:0];
                if (pc_next_wide >= LIMIT) state_d = ST_HALT;
            end

            // Entry 0 is always the head; entry 1 shifts down when the head leaves.
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        instr0_d = bus.IMemInstruction;
                        pc0_d    = pc_q;
                    end else begin
                        instr1_d = bus.IMemInstruction;
                        pc1_d    = pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    instr0_d = instr1_q;
                    pc0_d    = pc1_q;
                    count_d  = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        instr0_d = bus.IMemInstruction;
                        pc0_d    = pc_q;
                    end else begin
                        instr0_d = instr1_q;
                        pc0_d    = pc1_q;
                        instr1_d = bus.IMemInstruction;
                        pc1_d    = pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q     <= RESET_PC_ALIGN;
            state_q  <= ST_RESET;
            count_q  <= 2'd0;
            instr0_q <= 32'd0;
            pc0_q    <= 32'd0;
            instr1_q <= 32'd0;
            pc1_q    <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            count_q  <= count_d;
            instr0_q <= instr0_d;
            pc0_q    <= pc0_d;
            instr1_q <= instr1_d;
            pc1_q    <= pc1_d;
        end
    end

    assign bus.IMemAddress = pc_q;
    assign bus.InstrValid  = (count_q != 2'd0);
    assign bus.Instruction = instr0_q;
    assign bus.InstrPC     = pc0_q;
    assign bus.Halted      = (state_q == ST_HALT);

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // A flush only counts when it actually throws away buffered work.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + (push ? 32'd1 : 32'd0);
        flush_cnt_d = flush_cnt_q + ((bus.Redirect && (count_q != 2'd0)) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule
